// File: rtl/edge_stream_3x3.sv
// Streaming 3x3 edge detector: two line buffers build the window from a raster
// stream, then gradients, combine and output formatting run in three stages.
module edge_stream_3x3 #(
   parameter int PW     = 8,
   parameter int IMG_W  = 640,
   parameter int IMG_H  = 480,
   parameter int MODE   = 0,
   parameter int BINARY = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic          in_sof,
   input  logic [PW-1:0] in_pix,
   input  logic [PW+4:0] thr,
   output logic          out_valid,
   output logic          out_sof,
   output logic          out_eol,
   output logic [PW-1:0] out_pix
);
   localparam int GW = PW + 6;
   localparam int MW = GW + 1;
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam logic signed [GW-1:0] K3   = GW'(3);
   localparam logic signed [GW-1:0] K10  = GW'(10);
   localparam logic signed [MW-1:0] MAXP = MW'((1 << PW) - 1);

   typedef enum logic {WAIT_SOF, ACTIVE} state_t;

   state_t         state_reg, state_next;
   logic [CW-1:0]  col_reg, col_next, col_cur;
   logic [RW-1:0]  row_reg, row_next, row_cur;
   logic           accept, flush, last;

   logic [PW-1:0]  lb_a [IMG_W];
   logic [PW-1:0]  lb_b [IMG_W];
   logic [PW-1:0]  rd_a, rd_b;

   logic [PW-1:0]  p11, p12, p13, p21, p22, p23, p31, p32, p33;
   logic           v0, sof0, eol0;
   logic signed [GW-1:0] gx_reg, gy_reg, gx_next, gy_next;
   logic           v1, sof1, eol1;
   logic signed [MW-1:0] m_reg, m_next;
   logic           v2, sof2, eol2;
   logic [PW+4:0]  thr_q;
   logic [PW-1:0]  pix_next;

   function automatic logic signed [GW-1:0] ext(input logic [PW-1:0] p);
      return $signed({{(GW-PW){1'b0}}, p});
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= WAIT_SOF;
         col_reg   <= '0;
         row_reg   <= '0;
      end else begin
         state_reg <= state_next;
         col_reg   <= col_next;
         row_reg   <= row_next;
      end
   end

   // An sof pixel always restarts at (0,0), whether the frame was idle or active.
   always_comb begin
      accept     = in_valid && (in_sof || state_reg == ACTIVE);
      flush      = in_valid && in_sof && state_reg == ACTIVE;
      col_cur    = in_sof ? '0 : col_reg;
      row_cur    = in_sof ? '0 : row_reg;
      last       = (row_cur == RW'(IMG_H-1)) && (col_cur == CW'(IMG_W-1));
      state_next = state_reg;
      col_next   = col_reg;
      row_next   = row_reg;
      if (accept) begin
         if (last) begin
            state_next = WAIT_SOF;
            col_next   = '0;
            row_next   = '0;
         end else begin
            state_next = ACTIVE;
            if (col_cur == CW'(IMG_W-1)) begin
               col_next = '0;
               row_next = row_cur + 1'b1;
            end else begin
               col_next = col_cur + 1'b1;
               row_next = row_cur;
            end
         end
      end
   end

   // Reads are addressed one pixel ahead so the registered data lines up with the next accept.
   always_ff @(posedge clk) begin
      rd_a <= lb_a[col_next];
      rd_b <= lb_b[col_next];
      if (accept) begin
         lb_a[col_cur] <= in_pix;
         lb_b[col_cur] <= rd_a;
      end
   end

   always_comb begin
      gx_next = K3 * (ext(p11) + ext(p13)) + K10 * ext(p12)
              - K3 * (ext(p31) + ext(p33)) - K10 * ext(p32);
      gy_next = K3 * (ext(p11) + ext(p31)) + K10 * ext(p21)
              - K3 * (ext(p13) + ext(p33)) - K10 * ext(p23);
   end

   logic signed [MW-1:0] gxe, gye, sum, ax, ay, thr_e;
   always_comb begin
      gxe = $signed({gx_reg[GW-1], gx_reg});
      gye = $signed({gy_reg[GW-1], gy_reg});
      sum = gxe + gye;
      ax  = gx_reg[GW-1] ? -gxe : gxe;
      ay  = gy_reg[GW-1] ? -gye : gye;
      // Adding the sign bit before the shift makes the halving truncate toward zero.
      if (MODE == 0) m_next = (sum + $signed({{(MW-1){1'b0}}, sum[MW-1]})) >>> 1;
      else           m_next = ax + ay;
   end

   always_comb begin
      thr_e = $signed({{(MW-PW-5){1'b0}}, thr_q});
      if (BINARY != 0)          pix_next = (m_reg > thr_e) ? '1 : '0;
      else if (m_reg < 0)       pix_next = '0;
      else if (m_reg > MAXP)    pix_next = '1;
      else                      pix_next = m_reg[PW-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {p11, p12, p13, p21, p22, p23, p31, p32, p33} <= '0;
         {v0, sof0, eol0, v1, sof1, eol1, v2, sof2, eol2} <= '0;
         gx_reg    <= '0;
         gy_reg    <= '0;
         m_reg     <= '0;
         thr_q     <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
         out_pix   <= '0;
      end else begin
         if (accept) begin
            p11 <= (col_cur == '0) ? '0 : p12;
            p12 <= (col_cur == '0) ? '0 : p13;
            p21 <= (col_cur == '0) ? '0 : p22;
            p22 <= (col_cur == '0) ? '0 : p23;
            p31 <= (col_cur == '0) ? '0 : p32;
            p32 <= (col_cur == '0) ? '0 : p33;
            p13 <= rd_b;
            p23 <= rd_a;
            p33 <= in_pix;
         end
         if (accept && in_sof) thr_q <= thr;
         v0     <= accept && (row_cur >= RW'(2)) && (col_cur >= CW'(2));
         sof0   <= (row_cur == RW'(2)) && (col_cur == CW'(2));
         eol0   <= col_cur == CW'(IMG_W-1);
         gx_reg <= gx_next;
         gy_reg <= gy_next;
         v1     <= v0 && !flush;
         sof1   <= sof0;
         eol1   <= eol0;
         m_reg  <= m_next;
         v2     <= v1 && !flush;
         sof2   <= sof1;
         eol2   <= eol1;
         out_valid <= v2 && !flush;
         out_sof   <= v2 && !flush && sof2;
         out_eol   <= v2 && !flush && eol2;
         if (v2 && !flush) out_pix <= pix_next;
      end
   end
endmodule
